// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV64M multiply sequencer.
// Included by the sequencer FSM and its shift-add datapath.
package mul_pkg;

   typedef enum logic [2:0] {
      MS_IDLE,
      MS_PREP,
      MS_RUN,
      MS_FIX,
      MS_DONE
   } mul_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;

   function automatic logic a_is_signed(
      input logic [2:0] f3
   );
      return f3 != F3_MULHU;
   endfunction

   function automatic logic b_is_signed(
      input logic [2:0] f3
   );
      return (f3 == F3_MUL) || (f3 == F3_MULH);
   endfunction

   function automatic logic is_mul_class(
      input logic [6:0] opc,
      input logic [6:0] f7,
      input logic [2:0] f3
   );
      return (opc == OPC_RTYPE) &&
             (f7 == F7_MULDIV) && !f3[2];
   endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: product register, multiplicand, one
// add/shift step per strobe and the final sign correction.
module mul_shift_add_dp
   import mul_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  i_load,
   input  logic                  i_step,
   input  logic                  i_fix,
   input  logic                  i_neg,
   input  logic [DATA_W-1:0]     i_mag_a,
   input  logic [DATA_W-1:0]     i_mag_b,
   output logic [2*DATA_W-1:0]   o_fixed
);

   logic [2*DATA_W-1:0] r_prod;
   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_addend;
   logic [2*DATA_W-1:0] w_next;
   logic [2*DATA_W-1:0] w_neg;

   assign w_addend = r_prod[0] ?
                     {1'b0, r_mcand} : '0;
   assign w_sum    = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                     + w_addend;
   // Sum carry becomes the new top bit after the shift.
   assign w_next   = {w_sum, r_prod[DATA_W-1:1]};
   assign w_neg    = -r_prod;
   assign o_fixed  = i_neg ? w_neg : r_prod;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_prod  <= '0;
         r_mcand <= '0;
      end else if (i_load) begin
         r_prod  <= {{DATA_W{1'b0}}, i_mag_b};
         r_mcand <= i_mag_a;
      end else if (i_step) begin
         r_prod  <= w_next;
      end else if (i_fix) begin
         r_prod  <= o_fixed;
      end
   end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative RV64M multiply sequencer for EX: stalls the pipe
// while shifting, then releases it for one cycle with done.
module mul_seq_unit
   import mul_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              start,
   input  logic              flush,
   input  logic [2:0]        func3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CW = $clog2(DATA_W);

   mul_state_e          r_state;
   logic [CW-1:0]       r_cnt;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [2:0]          r_f3;
   logic                r_neg;
   logic                r_done;
   logic [DATA_W-1:0]   r_result;

   logic                w_sa;
   logic                w_sb;
   logic [DATA_W-1:0]   w_mag_a;
   logic [DATA_W-1:0]   w_mag_b;
   logic                w_go;
   logic                w_load;
   logic                w_step;
   logic                w_fix;
   logic                w_last;
   logic [2*DATA_W-1:0] w_fixed;

   assign w_sa    = a_is_signed(r_f3) & r_a[DATA_W-1];
   assign w_sb    = b_is_signed(r_f3) & r_b[DATA_W-1];
   // The most-negative value still fits as unsigned magnitude.
   assign w_mag_a = w_sa ? -r_a : r_a;
   assign w_mag_b = w_sb ? -r_b : r_b;

   assign w_go    = enable & ~flush;
   assign w_load  = w_go & (r_state == MS_PREP);
   assign w_step  = w_go & (r_state == MS_RUN);
   assign w_fix   = w_go & (r_state == MS_FIX);
   assign w_last  = r_cnt == CW'(DATA_W - 1);

   assign stall = ((r_state == MS_IDLE) & start
                 | (r_state == MS_PREP)
                 | (r_state == MS_RUN)
                 | (r_state == MS_FIX)) & ~flush;
   assign done   = r_done;
   assign result = r_result;

   mul_shift_add_dp #(
      .DATA_W (DATA_W)
   ) u_dp (
      .clk     (clk),
      .arst_n  (arst_n),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_fix   (w_fix),
      .i_neg   (r_neg),
      .i_mag_a (w_mag_a),
      .i_mag_b (w_mag_b),
      .o_fixed (w_fixed)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state  <= MS_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_f3     <= '0;
         r_neg    <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else if (enable) begin
         if (flush) begin
            r_state <= MS_IDLE;
            r_done  <= 1'b0;
         end else begin
            unique case (r_state)
               MS_IDLE: begin
                  if (start) begin
                     r_a     <= op_a;
                     r_b     <= op_b;
                     r_f3    <= func3;
                     r_state <= MS_PREP;
                  end
               end
               MS_PREP: begin
                  r_neg   <= w_sa ^ w_sb;
                  r_cnt   <= '0;
                  r_state <= MS_RUN;
               end
               MS_RUN: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) r_state <= MS_FIX;
               end
               MS_FIX: begin
                  r_result <= (r_f3 == F3_MUL) ?
                     w_fixed[DATA_W-1:0] :
                     w_fixed[2*DATA_W-1:DATA_W];
                  r_done   <= 1'b1;
                  r_state  <= MS_DONE;
               end
               MS_DONE: begin
                  r_done  <= 1'b0;
                  r_state <= MS_IDLE;
               end
               default: r_state <= MS_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: directed table,
// multi-cycle corner sequences and random vs. a 128-bit model.
module tb_mul_seq_unit;
   import mul_pkg::*;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        enable;
   logic        start;
   logic        flush;
   logic [2:0]  func3;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        stall;
   logic        done;
   logic [63:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[5];

   mul_seq_unit #(.DATA_W(64)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .enable (enable),
      .start  (start),
      .flush  (flush),
      .func3  (func3),
      .op_a   (op_a),
      .op_b   (op_b),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   // Product from sign/zero-extended 128-bit operands.
   function automatic logic [63:0] ref_mul(
      input logic [2:0]  f3,
      input logic [63:0] a,
      input logic [63:0] b
   );
      logic [127:0] ea;
      logic [127:0] eb;
      logic [127:0] p;
      ea = (f3 != 3'd3) ? {{64{a[63]}}, a}
                        : {64'd0, a};
      eb = (f3 <= 3'd1) ? {{64{b[63]}}, b}
                        : {64'd0, b};
      p  = ea * eb;
      return (f3 == 3'd0) ? p[63:0] : p[127:64];
   endfunction

   // Entered and left just after a rising edge.
   task automatic run_mul(
      input string       nm,
      input logic [2:0]  f3,
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [63:0] exp,
      input int          gs,
      input int          gl
   );
      int          cyc;
      int          stall_n;
      int          done_cyc;
      int          exp_done;
      logic [63:0] res;
      cyc      = 0;
      stall_n  = 0;
      done_cyc = -1;
      res      = '0;
      exp_done = 67 + gl;
      func3    = f3;
      op_a     = a;
      op_b     = b;
      start    = 1'b1;
      enable   = 1'b1;
      while (done_cyc < 0 && cyc < 300) begin
         @(negedge clk);
         if (stall) stall_n++;
         if (gl > 0 && cyc >= gs && cyc < gs + gl) begin
            chk({nm, "_frz_cnt"},
                64'(dut.r_cnt), 64'(gs - 2));
            chk({nm, "_frz_st"},
                64'(dut.r_state == MS_RUN), 64'd1);
         end
         if (done) begin
            done_cyc = cyc;
            res      = result;
            chk({nm, "_stall_at_done"},
                64'(stall), 64'd0);
         end else begin
            @(posedge clk);
            #1;
            cyc++;
            start  = 1'b0;
            enable = !(gl > 0 && cyc >= gs &&
                       cyc < gs + gl);
         end
      end
      if (done_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no done in %0d",
                  nm, cyc);
      end
      chk({nm, "_done_cyc"},
          64'(done_cyc), 64'(exp_done));
      chk({nm, "_stall_n"},
          64'(stall_n), 64'(exp_done));
      chk({nm, "_result"}, res, exp);
      @(posedge clk);
      #1;
      enable = 1'b1;
      @(negedge clk);
      chk({nm, "_post_stall"}, 64'(stall), 64'd0);
      chk({nm, "_post_done"}, 64'(done), 64'd0);
      chk({nm, "_post_idle"},
          64'(dut.r_state == MS_IDLE), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] last;
      logic [2:0]  rf3;
      logic [63:0] ra;
      logic [63:0] rb;
      int          dn;

      tbl[0] = '{"mul_7x6", 3'd0, 64'd7, 64'd6, 64'd42};
      tbl[1] = '{"mul_min", 3'd0,
                 64'h8000_0000_0000_0000, '1,
                 64'h8000_0000_0000_0000};
      tbl[2] = '{"mulh_m1", 3'd1, '1, '1, 64'd0};
      tbl[3] = '{"mulhu_max", 3'd3, '1, '1,
                 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[4] = '{"mulhsu_m1", 3'd2, '1, '1, '1};

      arst_n = 1'b0;
      enable = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      func3  = '0;
      op_a   = '0;
      op_b   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i])
         run_mul(tbl[i].nm, tbl[i].f3, tbl[i].a,
                 tbl[i].b, tbl[i].exp, 0, 0);

      run_mul("gap_3x5", 3'd0, 64'd3, 64'd5,
              64'd15, 10, 5);
      last = 64'd15;

      // Flush during RUN cycle 10.
      func3 = 3'd0;
      op_a  = 64'd11;
      op_b  = 64'd13;
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_idle",
          64'(dut.r_state == MS_IDLE), 64'd1);
      chk("flush_stall_after", 64'(stall), 64'd0);
      dn = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("flush_no_done", 64'(dn), 64'd0);
      chk("flush_result", result, last);
      @(posedge clk);
      #1;

      // start and flush together in IDLE.
      op_a  = 64'd100;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("sf_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("sf_idle",
          64'(dut.r_state == MS_IDLE), 64'd1);
      chk("sf_stall_after", 64'(stall), 64'd0);
      @(posedge clk);
      #1;

      // Async reset in RUN cycle 30.
      func3 = 3'd0;
      op_a  = 64'd123;
      op_b  = 64'd456;
      start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      arst_n = 1'b0;
      #1;
      chk("arst_stall", 64'(stall), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_result", result, 64'd0);
      chk("arst_cnt", 64'(dut.r_cnt), 64'd0);
      chk("arst_idle",
          64'(dut.r_state == MS_IDLE), 64'd1);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      run_mul("post_rst_9x9", 3'd0, 64'd9, 64'd9,
              64'd81, 0, 0);

      for (int i = 0; i < 24; i++) begin
         rf3 = 3'($urandom_range(0, 3));
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0)
            ra = 64'h8000_0000_0000_0000;
         if ($urandom_range(0, 4) == 0)
            rb = '1;
         run_mul("rand", rf3, ra, rb,
                 ref_mul(rf3, ra, rb), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

- Iterative 64-bit RV64M multiply sequencer for the EX stage of the 5-stage pipeline.
- Accepts a MUL-class instruction from ID/EX and computes the product one bit per cycle (shift-add).
- While it works, it drives `stall`, which holds the PC and all pipeline registers.
- On completion it releases the pipeline for exactly one cycle, with the result valid for capture into EX/MEM.

## Interface
- `DATA_W`, default 64: operand and result width. Must be a power of two, ≥ 8.
- `clk`, input, 1: main clock; all state updates on the rising edge.
- `arst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: global run enable. When low, all internal state holds.
- `start`, input, 1: EX holds a valid MUL-class instruction (decode of opcode 0110011 with funct7 = 0000001 and funct3[2] = 0).
- `flush`, input, 1: kill the instruction in EX. Synchronous abort.
- `func3`, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `op_a`, input, DATA_W: rs1 value from ID/EX.
- `op_b`, input, DATA_W: rs2 value from ID/EX.
- `stall`, output, 1: freeze PC and pipeline registers. Pipeline enables are `enable & ~stall`.
- `done`, output, 1: `result` is valid this cycle. The EX result mux selects `result` over `alu_out`.
- `result`, output, DATA_W: product word, held until the next start.

## Operation
- States:
  - IDLE
  - PREP
  - RUN
  - FIX
  - DONE
- IDLE:
  - On `enable & start & ~flush`: latch `op_a`, `op_b`, `func3` and go to PREP.
  - Otherwise stay.
- PREP:
  - Form unsigned magnitudes: `a` is treated as signed for MUL, MULH and MULHSU; `b` is treated as signed for MUL and MULH.
  - Record `neg = sign_a ^ sign_b` using only the operands treated as signed.
  - Load the product register {DATA_W'0, |b|} and the multiplicand |a|.
  - Clear the counter. Go to RUN.
- RUN, per cycle:
  - If product[0] is set: prod_hi = prod_hi + multiplicand, kept as a DATA_W+1-bit sum.
  - Shift the 2·DATA_W+1-bit concatenation right by 1.
  - Increment the counter ($clog2(DATA_W) bits).
  - Leave for FIX after DATA_W iterations, i.e. when the counter equals DATA_W-1.
- FIX:
  - If `neg`, take the 2·DATA_W-bit two's complement of the product.
  - Latch `result`: low word for MUL, high word otherwise. Go to DONE.
- DONE:
  - `stall` = 0 and `done` = 1.
  - The pipeline advances at this edge. Return to IDLE unconditionally.
- `stall` = ((state==IDLE & start) | state∈{PREP, RUN, FIX}) & ~flush, computed combinationally.
  - This asserts in the same cycle `start` rises, so ID/EX never advances past an unstarted multiply.
- `flush` in any non-IDLE state: go to IDLE next edge. `result` and `done` do not change. `stall` drops in the flush cycle.
- `flush` and `start` together in IDLE: flush wins, no capture.
- `enable` low: state, counter and datapath all hold. `stall` keeps its decoded value.
- Most-negative operand (−2^(DATA_W−1)): its magnitude fits unsigned in DATA_W bits. No special case.
- Reset values, and state after async reset at any point including mid-RUN:
  - state IDLE, counter 0, `result` 0, `done` 0, `stall` 0 while `start` is 0, all datapath registers 0.

## Timing
- Cycle 0 is the IDLE cycle with `start` = 1.
- Cycle 1 is PREP. RUN occupies cycles 2 … DATA_W+1. FIX is cycle DATA_W+2. DONE is cycle DATA_W+3.
- `stall` is high for cycles 0 … DATA_W+2: 67 cycles at DATA_W = 64.
- `done` pulses for one cycle at cycle DATA_W+3: cycle 67.
- The next MUL can start at cycle DATA_W+4, back-to-back with no bubble beyond the pipeline advance.
- Every cycle with `enable` low extends all of the above by one cycle.

## Structure
- Shared package `mul_pkg`:
  - state enum: MS_IDLE, MS_PREP, MS_RUN, MS_FIX, MS_DONE.
  - funct3 constants: F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - constants F7_MULDIV = 7'b0000001 and OPC_RTYPE = 7'b0110011.
- One sub-module, `mul_shift_add_dp`:
  - Holds the product register, multiplicand, add-shift step and final negation.
  - Controlled by load/step/fix strobes from the FSM in `mul_seq_unit`.
  - The counter, `neg`/sign logic and stall/done decode stay in `mul_seq_unit`.

## Test plan
- MUL 7 × 6: `stall` high 67 cycles, `done` at cycle 67, `result` = 42. Next cycle back in IDLE with `stall` = 0.
- MUL −2^63 × −1: `result` = 0x8000_0000_0000_0000. MULH −1 × −1: `result` = 0.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF: `result` = 0xFFFF_FFFF_FFFF_FFFE. MULHSU op_a = −1, op_b = 0xFFFF_FFFF_FFFF_FFFF: `result` = 0xFFFF_FFFF_FFFF_FFFF.
- MUL 3 × 5 with `enable` low for 5 cycles during RUN: `done` at cycle 72, `result` = 15. Assert that state and counter are frozen while `enable` is low.
- `flush` in RUN cycle 10: `stall` drops in that cycle, IDLE next edge, no `done`, `result` unchanged. `start` + `flush` together in IDLE: no capture, `stall` = 0.
- `arst_n` pulsed low in RUN cycle 30: all outputs 0 immediately. After release, a fresh MUL 9 × 9 gives 81 at cycle 67.
